// File: rtl/breath_seq_ctrl.sv
// Breathing-LED sequencer: prescaler, PWM period counter, duty ramp and
// sync/chase scheduling across NUM_LED outputs.
module breath_seq_ctrl #(
    parameter int CLK_DIV   = 100,
    parameter int PWM_STEPS = 1000,
    parameter int NUM_LED   = 4,
    parameter int CNT_W     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               done,
    output logic [3:0]         cur_ch,
    output logic [NUM_LED-1:0] led
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(PWM_STEPS - 1);
    localparam logic [3:0]       CH_MAX   = 4'(NUM_LED - 1);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   pwm_q, pwm_d;
    logic [CNT_W-1:0]   duty_q, duty_d;
    logic [3:0]         ch_q, ch_d;
    logic               stop_q, stop_d;
    logic               done_q, done_d;

    logic               tick, pend, chase, loop_m, lit;
    logic [CNT_W-1:0]   bright;

    // mode: 00 sync-once, 01 chase-once, 10 chase-loop, 11 sync-loop
    assign chase  = mode_q[0] ^ mode_q[1];
    assign loop_m = mode_q[1];
    assign tick   = (div_q == DIV_MAX);
    assign pend   = tick && (pwm_q == STEP_MAX);
    assign bright = (state_q == DOWN) ? STEP_MAX - duty_q : duty_q;
    assign lit    = (state_q != IDLE) && (pwm_q < bright);

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign cur_ch = ch_q;

    always_comb begin
        for (int i = 0; i < NUM_LED; i++) begin
            led[i] = lit && (!chase || ch_q == 4'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        div_d   = div_q;
        pwm_d   = pwm_q;
        duty_d  = duty_q;
        ch_d    = ch_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                div_d  = '0;
                pwm_d  = '0;
                duty_d = '0;
                if (start) begin
                    mode_d  = mode;
                    ch_d    = '0;
                    stop_d  = 1'b0;
                    state_d = UP;
                end
            end
            UP, DOWN: begin
                if (stop) stop_d = 1'b1;
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) pwm_d = (pwm_q == STEP_MAX) ? '0 : pwm_q + 1'b1;
                if (pend) begin
                    if (duty_q != STEP_MAX) begin
                        duty_d = duty_q + 1'b1;
                    end else begin
                        duty_d = '0;
                        if (state_q == UP) begin
                            state_d = DOWN;
                        end else if (stop_q ||
                                     (!loop_m && (!chase || ch_q == CH_MAX))) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            ch_d    = '0;
                            stop_d  = 1'b0;
                        end else begin
                            state_d = UP;
                            if (chase) ch_d = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            div_q   <= '0;
            pwm_q   <= '0;
            duty_q  <= '0;
            ch_q    <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            div_q   <= div_d;
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
            ch_q    <= ch_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_breath_seq_ctrl.sv
// Bench for breath_seq_ctrl: outputs predicted from elapsed time since start
// (breath index, half, duty step, PWM phase) and compared every cycle.
module tb_breath_seq_ctrl;

    localparam int CD = 2;
    localparam int PS = 4;
    localparam int NL = 4;
    localparam int BREATH = 2 * PS * PS * CD;

    logic          clk = 1'b0;
    logic          rst, start, stop;
    logic [1:0]    mode;
    logic          busy, done;
    logic [3:0]    cur_ch;
    logic [NL-1:0] led;

    int checks = 0;
    int errors = 0;

    breath_seq_ctrl #(
        .CLK_DIV(CD), .PWM_STEPS(PS), .NUM_LED(NL), .CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .busy(busy), .done(done), .cur_ch(cur_ch), .led(led)
    );

    always #5 clk = ~clk;

    // Expected {busy, done, cur_ch, led} t edges after the accepting edge.
    function automatic logic [NL+5:0] model(input logic [1:0] m,
                                            input int t, input int fin);
        int b, w, duty, pwm, bright, ch;
        bit chs, lit;
        logic [NL-1:0] l;
        if (t == fin) return {1'b0, 1'b1, 4'd0, {NL{1'b0}}};
        if (t > fin) return '0;
        b = t / BREATH;
        w = t % BREATH;
        duty = (w % (BREATH / 2)) / (PS * CD);
        pwm = (w % (PS * CD)) / CD;
        bright = (w >= BREATH / 2) ? PS - 1 - duty : duty;
        lit = pwm < bright;
        chs = (m == 2'b01) || (m == 2'b10);
        ch = chs ? b % NL : 0;
        l = '0;
        if (chs) l[ch] = lit;
        else l = {NL{lit}};
        return {1'b1, 1'b0, 4'(ch), l};
    endfunction

    task automatic check(input string tag, input int t,
                         input logic [NL+5:0] exp);
        logic [NL+5:0] obs;
        obs = {busy, done, cur_ch, led};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    // Times are the cycle index t during which the input is held high.
    task automatic run(input string tag, input logic [1:0] m,
                       input int stop_s, input int stop2_s, input int start_s,
                       input bit stop_w_start, input int rst_s);
        int nat, n, fin;
        bit once, chs;
        once = (m == 2'b00) || (m == 2'b01);
        chs  = (m == 2'b01) || (m == 2'b10);
        nat  = once ? (chs ? NL : 1) : 1000;
        n    = nat;
        if (stop_s >= 0 && (stop_s + 1) / BREATH + 1 < n)
            n = (stop_s + 1) / BREATH + 1;
        fin = n * BREATH;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        stop  = stop_w_start;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'($urandom);
        check(tag, 0, model(m, 0, fin));
        for (int t = 0; t <= fin; t++) begin
            stop  = (t == stop_s) || (t == stop2_s);
            start = (t == start_s);
            rst   = (t == rst_s);
            mode  = 2'($urandom);
            @(posedge clk);
            #1;
            stop  = 1'b0;
            start = 1'b0;
            if (rst) begin
                rst = 1'b0;
                check({tag, "_rst"}, t + 1, '0);
                return;
            end
            check(tag, t + 1, model(m, t + 1, fin));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle", 0, '0);

        run("sync_once",  2'b00, -1, -1, -1, 1'b0, -1);
        run("chase_once", 2'b01, -1, -1, -1, 1'b0, -1);
        run("chase_stop", 2'b10, 149, -1, -1, 1'b0, -1);
        run("sync_loop",  2'b11, 9, 19, 29, 1'b0, -1);
        run("start_stop", 2'b00, -1, -1, -1, 1'b1, -1);
        run("mid_rst",    2'b01, -1, -1, -1, 1'b0, 99);
        run("after_rst",  2'b01, -1, -1, -1, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            logic [1:0] m;
            int ss, st;
            m  = 2'($urandom);
            ss = $urandom_range(0, 300);
            if (!m[1] && $urandom_range(0, 1) == 1) ss = -1;
            st = $urandom_range(0, 200);
            run("random", m, ss, -1, st, 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
